// File: rtl/idt_cfg_pkg.sv
// ---------------------------------------------------------------------------
// idt_cfg_pkg : field layout, bit count and power-up word of the IDT config
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package idt_cfg_pkg;

   localparam int CFG_BITS = 24;

   // Field widths and LSB offsets of {C, TTL, F, S, V, R}
   localparam int R_W   = 7;
   localparam int R_LSB = 0;
   localparam int V_W   = 9;
   localparam int V_LSB = R_LSB + R_W;
   localparam int S_W   = 3;
   localparam int S_LSB = V_LSB + V_W;
   localparam int F_W   = 2;
   localparam int F_LSB = S_LSB + S_W;
   localparam int TTL_W   = 1;
   localparam int TTL_LSB = F_LSB + F_W;
   localparam int C_W   = 2;
   localparam int C_LSB = TTL_LSB + TTL_W;

   localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 24'h31149F;
   localparam logic [4:0]          LAST_BIT    = 5'(CFG_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_STROBE = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/idt_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// idt_cfg_loader_if : config handshake, status and serial pins of the loader
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface idt_cfg_loader_if;
   import idt_cfg_pkg::*;

   logic                cfg_valid;
   logic [CFG_BITS-1:0] cfg_word;
   logic                cfg_ready;
   logic                busy;
   logic                done;
   logic                idt_sclk;
   logic                idt_data;
   logic                idt_strobe;

   modport master (
      output cfg_valid, cfg_word,
      input  cfg_ready, busy, done, idt_sclk, idt_data, idt_strobe
   );

   modport slave (
      input  cfg_valid, cfg_word,
      output cfg_ready, busy, done, idt_sclk, idt_data, idt_strobe
   );

endinterface

`default_nettype wire

// File: rtl/idt_cfg_tick.sv
// ---------------------------------------------------------------------------
// idt_cfg_tick : half-period tick generator, one tick every CLK_DIV enabled cycles
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idt_cfg_tick #(
   parameter int CLK_DIV = 4
) (
   input  wire logic osc_clk,
   input  wire logic osc_reset_,
   input  wire logic en,
   output logic      tick
);

   localparam logic [7:0] DIV = 8'(CLK_DIV);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Counts 1..DIV while enabled and parks at 0 otherwise, so the first
   // half-period after enable spans the enabling cycle plus DIV more.
   assign tick = en && (cnt_q == DIV);

   always_comb begin
      cnt_d = 8'd0;
      if (en) begin
         cnt_d = (cnt_q == DIV) ? 8'd1 : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge osc_clk or negedge osc_reset_) begin
      if (!osc_reset_) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/idt_cfg_loader.sv
// ---------------------------------------------------------------------------
// idt_cfg_loader : serial loader of the 24-bit IDT synthesizer config word
// Option macro   : IDT_CFG_AUTOLOAD_EN loads DEFAULT_CFG right after reset
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idt_cfg_loader
   import idt_cfg_pkg::*;
#(
   parameter int                  CLK_DIV       = 4,
   parameter int                  STROBE_CYCLES = 4,
   parameter logic [CFG_BITS-1:0] DEFAULT_CFG   = CFG_DEFAULT
) (
   input wire logic         osc_clk,
   input wire logic         osc_reset_,
   idt_cfg_loader_if.slave  bus
);

   localparam logic [7:0] STB_LEN = 8'(STROBE_CYCLES);

`ifdef IDT_CFG_AUTOLOAD_EN
   localparam logic READY_RST = 1'b0;
`else
   localparam logic READY_RST = 1'b1;
`endif

   state_e              state_q, state_d;
   logic [CFG_BITS-1:0] shreg_q, shreg_d;
   logic [4:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          stb_cnt_q, stb_cnt_d;
   logic                sclk_q, sclk_d;
   logic                strobe_q, strobe_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic                start;
   logic [CFG_BITS-1:0] load_word;
   logic                tick;

`ifdef IDT_CFG_AUTOLOAD_EN
   logic autoload_q, autoload_d;
`endif

   idt_cfg_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .osc_clk    (osc_clk),
      .osc_reset_ (osc_reset_),
      .en         (state_q == ST_SHIFT),
      .tick       (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      stb_cnt_d = stb_cnt_q;
      sclk_d    = sclk_q;
      strobe_d  = strobe_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      start     = 1'b0;
      load_word = bus.cfg_word;
`ifdef IDT_CFG_AUTOLOAD_EN
      autoload_d = autoload_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef IDT_CFG_AUTOLOAD_EN
            if (autoload_q) begin
               start      = 1'b1;
               load_word  = DEFAULT_CFG;
               autoload_d = 1'b0;
            end else
`endif
            if (bus.cfg_valid && ready_q) begin
               start = 1'b1;
            end
            if (start) begin
               state_d   = ST_SHIFT;
               shreg_d   = load_word;
               bit_idx_d = 5'd0;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_idx_q == LAST_BIT) begin
                  state_d   = ST_STROBE;
                  sclk_d    = 1'b0;
                  shreg_d   = '0;
                  strobe_d  = 1'b1;
                  stb_cnt_d = 8'd1;
               end else begin
                  // Data only moves on the falling edge of sclk.
                  sclk_d    = 1'b0;
                  shreg_d   = {shreg_q[CFG_BITS-2:0], 1'b0};
                  bit_idx_d = bit_idx_q + 5'd1;
               end
            end
         end

         ST_STROBE: begin
            if (stb_cnt_q == STB_LEN) begin
               state_d  = ST_IDLE;
               strobe_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               ready_d  = 1'b1;
            end else begin
               stb_cnt_d = stb_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            shreg_d  = '0;
            sclk_d   = 1'b0;
            strobe_d = 1'b0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge osc_clk or negedge osc_reset_) begin
      if (!osc_reset_) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_idx_q <= 5'd0;
         stb_cnt_q <= 8'd0;
         sclk_q    <= 1'b0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= READY_RST;
`ifdef IDT_CFG_AUTOLOAD_EN
         autoload_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         stb_cnt_q <= stb_cnt_d;
         sclk_q    <= sclk_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
`ifdef IDT_CFG_AUTOLOAD_EN
         autoload_q <= autoload_d;
`endif
      end
   end

   // The serial data pin is the MSB flop of the shift register itself.
   assign bus.idt_data   = shreg_q[CFG_BITS-1];
   assign bus.idt_sclk   = sclk_q;
   assign bus.idt_strobe = strobe_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cfg_ready  = ready_q;

endmodule

`default_nettype wire
